// File: rtl/nh_pkg.sv
// Shared NewHope constants, parameter-set derivations and the polynomial
// sequencer state type.
package nh_pkg;

  localparam int NEWHOPE_Q  = 12289;
  localparam int NEWHOPE_2Q = 24578;
  localparam int COEFF_W    = 16;

  localparam int N_512       = 512;
  localparam int ADDR_W_512  = $clog2(N_512);
  localparam int N_1024      = 1024;
  localparam int ADDR_W_1024 = $clog2(N_1024);

  localparam int RD_LAT     = 1;
  localparam int ADD_LAT    = 2;
  localparam int PIPE_DEPTH = RD_LAT + ADD_LAT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } poly_ctrl_state_t;

  // Two-step conditional subtraction: canonical for sums below 3q, and keeps
  // sums of [0,2q) inputs inside [0,2q).
  function automatic logic [COEFF_W-1:0] mod_reduce(input logic [COEFF_W:0] s);
    logic [COEFF_W:0] r;
    if (s >= (COEFF_W+1)'(NEWHOPE_2Q))
      r = s - (COEFF_W+1)'(NEWHOPE_2Q);
    else if (s >= (COEFF_W+1)'(NEWHOPE_Q))
      r = s - (COEFF_W+1)'(NEWHOPE_Q);
    else
      r = s;
    return r[COEFF_W-1:0];
  endfunction

endpackage

// File: rtl/poly_add_ctrl_if.sv
// Coefficient RAM port bundle between the add sequencer (master) and the
// A/B read ports plus the C write port (slave).
interface poly_add_ctrl_if #(
    parameter int ADDR_W = 10
);
    import nh_pkg::*;

    // rd_en/rd_addr issue a read; a_rdata/b_rdata are valid RD_LAT cycles
    // later. wr_en qualifies wr_addr/wr_data for a single-cycle write.
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [COEFF_W-1:0] a_rdata;
    logic [COEFF_W-1:0] b_rdata;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COEFF_W-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  a_rdata, b_rdata
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output a_rdata, b_rdata
    );

endinterface

// File: rtl/poly_add_coeff.sv
// Single-coefficient modular adder: registered sum, then registered
// reduction mod q. Two-cycle start-to-result latency, no reset.
module poly_add_coeff
    import nh_pkg::*;
(
    input  logic               clk,
    input  logic               start,
    input  logic [COEFF_W-1:0] a,
    input  logic [COEFF_W-1:0] b,
    output logic [COEFF_W-1:0] dout
);

    logic [COEFF_W:0] sum_q;

    always_ff @(posedge clk) begin
        if (start)
            sum_q <= {1'b0, a} + {1'b0, b};
    end

    always_ff @(posedge clk) begin
        dout <= mod_reduce(sum_q);
    end

endmodule

// File: rtl/poly_add_ctrl.sv
// Streams c = a + b mod q over a whole polynomial, one coefficient per cycle,
// from RAMs A/B through poly_add_coeff into RAM C.
module poly_add_ctrl
    import nh_pkg::*;
#(
    parameter int N      = 1024,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output poly_ctrl_state_t state_dbg,
    poly_add_ctrl_if.master  ram
);

    poly_ctrl_state_t  state, state_nxt;
    logic [ADDR_W-1:0] counter, counter_nxt;
    logic              rd_en_c;
    logic              done_c;

    logic [PIPE_DEPTH-1:0] vld_sr;
    logic [ADDR_W-1:0]     addr_dl [PIPE_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= state_nxt;
            counter <= counter_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        counter_nxt = counter;
        rd_en_c     = 1'b0;
        done_c      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = RUN;
                    counter_nxt = '0;
                end
            end
            RUN: begin
                rd_en_c     = 1'b1;
                counter_nxt = counter + 1'b1;
                if (counter == ADDR_W'(N - 1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Done only once the last write has left the pipeline.
                if (vld_sr == '0) begin
                    done_c    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Valid and address travel together: read -> adder start -> sum -> write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++)
                addr_dl[i] <= '0;
        end else begin
            vld_sr     <= {vld_sr[PIPE_DEPTH-2:0], rd_en_c};
            addr_dl[0] <= counter;
            for (int i = 1; i < PIPE_DEPTH; i++)
                addr_dl[i] <= addr_dl[i-1];
        end
    end

    assign busy      = (state != IDLE) && !done_c;
    assign done      = done_c;
    assign state_dbg = state;

    assign ram.rd_en   = rd_en_c;
    assign ram.rd_addr = counter;
    assign ram.wr_en   = vld_sr[PIPE_DEPTH-1];
    assign ram.wr_addr = addr_dl[PIPE_DEPTH-1];

    poly_add_coeff u_add (
        .clk   (clk),
        .start (vld_sr[RD_LAT-1]),
        .a     (ram.a_rdata),
        .b     (ram.b_rdata),
        .dout  (ram.wr_data)
    );

endmodule

// File: tb/tb_poly_add_ctrl.sv
// Bench for poly_add_ctrl: an N=8 instance for directed timing cases and an
// N=1024 instance for a full random polynomial, both against a cycle model.
module tb_poly_add_ctrl;
  import nh_pkg::*;

  localparam int Q = 12289;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start8, start1k;
  logic busy8, done8, busy1k, done1k;
  poly_ctrl_state_t st8, st1k;

  poly_add_ctrl_if #(.ADDR_W(3))  ram8 ();
  poly_add_ctrl_if #(.ADDR_W(10)) ram1k ();

  poly_add_ctrl #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .busy(busy8), .done(done8),
    .state_dbg(st8), .ram(ram8)
  );

  poly_add_ctrl #(.N(1024)) dut1k (
    .clk(clk), .rst(rst), .start(start1k), .busy(busy1k), .done(done1k),
    .state_dbg(st1k), .ram(ram1k)
  );

  // ---------------- RAM models ----------------
  logic [15:0] mem_a [2][1024];
  logic [15:0] mem_b [2][1024];
  logic [15:0] mem_c [2][1024];

  always @(posedge clk) begin
    if (ram8.rd_en) begin
      ram8.a_rdata <= mem_a[0][ram8.rd_addr];
      ram8.b_rdata <= mem_b[0][ram8.rd_addr];
    end
    if (ram8.wr_en) mem_c[0][ram8.wr_addr] <= ram8.wr_data;
    if (ram1k.rd_en) begin
      ram1k.a_rdata <= mem_a[1][ram1k.rd_addr];
      ram1k.b_rdata <= mem_b[1][ram1k.rd_addr];
    end
    if (ram1k.wr_en) mem_c[1][ram1k.wr_addr] <= ram1k.wr_data;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act_v, exp_v);
    end
  endtask

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  bit act [2];
  int s_cyc [2];
  int done_cnt [2];
  int done_cyc [2];

  // Operation model: an accepted start at cycle s reads index d-1 in cycle d
  // (1..N), writes index d-4 in cycle d (4..N+3), is busy 1..N+3, done at N+4.
  task automatic model_step(input int idx, input int nn, input logic st, input logic bsy,
                            input logic dn, input logic rde, input logic [31:0] rda,
                            input logic wre, input logic [31:0] wra, input logic [31:0] wrd);
    int d;
    logic [15:0] e;
    d = act[idx] ? cyc - s_cyc[idx] : -1;
    chk("rd_en", 32'(rde), 32'(d >= 1 && d <= nn));
    if (d >= 1 && d <= nn) chk("rd_addr", rda, 32'(d - 1));
    chk("busy", 32'(bsy), 32'(d >= 1 && d <= nn + 3));
    chk("done", 32'(dn), 32'(d == nn + 4));
    chk("wr_en", 32'(wre), 32'(d >= 4 && d <= nn + 3));
    if (d >= 4 && d <= nn + 3) begin
      chk("wr_addr", wra, 32'(d - 4));
      if (idx == 0) begin
        if (exp_q0.size() == 0) e = 16'hxxxx; else e = exp_q0.pop_front();
      end else begin
        if (exp_q1.size() == 0) e = 16'hxxxx; else e = exp_q1.pop_front();
      end
      chk("wr_data", wrd, 32'(e));
    end
    if (dn === 1'b1) begin
      done_cnt[idx]++;
      done_cyc[idx] = cyc;
    end
    if (st === 1'b1 && !act[idx]) begin
      act[idx]   = 1'b1;
      s_cyc[idx] = cyc;
      for (int i = 0; i < nn; i++) begin
        e = 16'((int'(mem_a[idx][i]) + int'(mem_b[idx][i])) % Q);
        if (idx == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      end
    end else if (act[idx] && d == nn + 4) begin
      act[idx] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      act[0] = 1'b0;
      act[1] = 1'b0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      model_step(0, 8, start8, busy8, done8, ram8.rd_en, 32'(ram8.rd_addr),
                 ram8.wr_en, 32'(ram8.wr_addr), 32'(ram8.wr_data));
      model_step(1, 1024, start1k, busy1k, done1k, ram1k.rd_en, 32'(ram1k.rd_addr),
                 ram1k.wr_en, 32'(ram1k.wr_addr), 32'(ram1k.wr_data));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse8;
    start8 = 1'b1;
    step(1);
    start8 = 1'b0;
  endtask

  task automatic load_rand(input int idx, input int nn);
    for (int i = 0; i < nn; i++) begin
      mem_a[idx][i] = 16'($urandom_range(Q - 1, 0));
      mem_b[idx][i] = 16'($urandom_range(Q - 1, 0));
    end
  endtask

  task automatic check_c(input int idx, input int nn, input string name);
    for (int i = 0; i < nn; i++)
      chk(name, 32'(mem_c[idx][i]), (int'(mem_a[idx][i]) + int'(mem_b[idx][i])) % Q);
  endtask

  // ---------------- stimulus ----------------
  int s, d0;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_a[0][i] = '0; mem_b[0][i] = '0; mem_a[1][i] = '0; mem_b[1][i] = '0;
    end
    start8  = 1'b0;
    start1k = 1'b0;
    rst     = 1'b0;
    #1 rst  = 1'b1;
    #2;
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_rd_en", 32'(ram8.rd_en), 0);
    chk("rst_wr_en", 32'(ram8.wr_en), 0);
    chk("rst_rd_addr", 32'(ram8.rd_addr), 0);
    chk("rst_wr_addr", 32'(ram8.wr_addr), 0);
    chk("rst_state", 32'(st8), 32'(IDLE));
    chk("rst_busy_1k", 32'(busy1k), 0);
    chk("rst_state_1k", 32'(st1k), 32'(IDLE));
    step(2);
    rst = 1'b0;
    step(2);

    // Linear pattern: C[i] = 100 + 2i.
    for (int i = 0; i < 8; i++) begin
      mem_a[0][i] = 16'(i);
      mem_b[0][i] = 16'(100 + i);
    end
    d0 = done_cnt[0];
    s  = cyc;
    pulse8;
    step(13);
    chk("lin_done_cnt", done_cnt[0] - d0, 1);
    chk("lin_done_cyc", done_cyc[0] - s, 12);
    for (int i = 0; i < 8; i++) chk("lin_c", 32'(mem_c[0][i]), 100 + 2 * i);

    // Reduction boundaries.
    load_rand(0, 8);
    mem_a[0][0] = 16'd12288; mem_b[0][0] = 16'd1;
    mem_a[0][1] = 16'd12288; mem_b[0][1] = 16'd12288;
    mem_a[0][2] = 16'd6000;  mem_b[0][2] = 16'd6288;
    mem_a[0][3] = 16'd0;     mem_b[0][3] = 16'd0;
    pulse8;
    step(14);
    chk("bnd_c0", 32'(mem_c[0][0]), 0);
    chk("bnd_c1", 32'(mem_c[0][1]), 12287);
    chk("bnd_c2", 32'(mem_c[0][2]), 12288);
    chk("bnd_c3", 32'(mem_c[0][3]), 0);
    check_c(0, 8, "bnd_rest");

    // Starts in cycles 3 and 12 are ignored; cycle 13 launches a new op.
    load_rand(0, 8);
    d0 = done_cnt[0];
    s  = cyc;
    for (int rel = 0; rel < 27; rel++) begin
      start8 = (rel == 0 || rel == 3 || rel == 12 || rel == 13);
      if (rel == 20) chk("repulse_first_done", done_cnt[0] - d0, 1);
      step(1);
    end
    start8 = 1'b0;
    chk("repulse_done_cnt", done_cnt[0] - d0, 2);
    chk("repulse_done_cyc", done_cyc[0] - s, 25);
    check_c(0, 8, "repulse_c");

    // Asynchronous abort in cycle 6.
    load_rand(0, 8);
    d0 = done_cnt[0];
    pulse8;
    step(5);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy8), 0);
    chk("abort_rd_en", 32'(ram8.rd_en), 0);
    chk("abort_wr_en", 32'(ram8.wr_en), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    step(10);
    chk("abort_no_done", done_cnt[0] - d0, 0);
    load_rand(0, 8);
    s = cyc;
    pulse8;
    step(13);
    chk("after_abort_done", done_cyc[0] - s, 12);
    check_c(0, 8, "after_abort_c");

    // Back-to-back: second start in the cycle right after done.
    load_rand(0, 8);
    s = cyc;
    pulse8;
    step(12);
    chk("b2b_first_done", done_cyc[0] - s, 12);
    load_rand(0, 8);
    s = cyc;
    pulse8;
    step(13);
    chk("b2b_second_done", done_cyc[0] - s, 12);
    check_c(0, 8, "b2b_c");

    // Full-size random polynomial.
    load_rand(1, 1024);
    d0 = done_cnt[1];
    s  = cyc;
    start1k = 1'b1;
    step(1);
    start1k = 1'b0;
    step(1031);
    chk("big_done_cnt", done_cnt[1] - d0, 1);
    chk("big_done_cyc", done_cyc[1] - s, 1028);
    check_c(1, 1024, "big_c");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_add_ctrl.md
Name: poly_add_ctrl

Overview:
Sequencer that streams a full polynomial addition c = a + b mod q (q = 12289) through the single-coefficient modular adder.
- Issues one read address per cycle to the A and B coefficient RAMs.
- Feeds the returned words into the adder.
- Writes the reduced results to the C RAM at the matching address.
- Sits between the top-level NewHope control FSM (start/done) and the three polynomial BRAMs; throughput is 1 coefficient/cycle.

Parameters:
N, 1024, coefficients per polynomial (512 for NewHope-512); must be a power of 2.
ADDR_W, 10, coefficient address width, equal to log2(N).
RD_LAT, 1, BRAM read latency in cycles; fixed at 1.
ADD_LAT, 2, adder start-to-done latency in cycles; fixed at 2.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins one polynomial add
busy  out  1  high while an operation is in flight
done  out  1  single-cycle pulse after the last coefficient is written
rd_en  out  1  read enable to RAM A and RAM B
rd_addr  out  ADDR_W  shared read address for RAM A and RAM B
a_rdata  in  16  RAM A read data, valid RD_LAT cycles after rd_en
b_rdata  in  16  RAM B read data, valid RD_LAT cycles after rd_en
wr_en  out  1  write enable to RAM C
wr_addr  out  ADDR_W  RAM C write address
wr_data  out  16  reduced sum, taken directly from the adder's registered output

Behaviour:
- Reset: rst is asynchronous, active-high. It forces:
  - state=IDLE;
  - counter=0;
  - busy, done, rd_en, wr_en = 0;
  - rd_addr and wr_addr = 0;
  - valid and address delay lines cleared.
- wr_data reset value is don't-care: the adder has no reset, so wr_en is never qualified by the adder's done output. It is driven only by the controller's own 3-stage valid shift register (RD_LAT + ADD_LAT), which is cleared by rst.
- FSM: IDLE -> RUN -> DRAIN -> IDLE.
  - IDLE: start=1 -> RUN, counter=0.
  - RUN: rd_en=1, rd_addr=counter, counter++. When counter==N-1 is issued -> DRAIN.
  - DRAIN: rd_en=0. Wait until the valid shift register is empty, then pulse done for 1 cycle -> IDLE.
- Timing, with the start pulse in cycle 0:
  - rd_en high in cycles 1..N, with rd_addr = k-1 in cycle k.
  - RAM data valid in cycle k+1; the adder is driven in that cycle (adder start = delayed rd_en).
  - wr_en high in cycles 4..N+3, with wr_addr = k-1 in cycle k+3 and wr_data = adder dout.
  - done=1 in cycle N+4 only.
  - busy=1 in cycles 1..N+3.
  - Total latency from start to done is N+4 cycles.
- wr_addr comes from a 3-deep address delay line; it is not a second counter.
- The counter wraps naturally at ADDR_W bits; the RUN exit compares against N-1 explicitly.
- start while busy=1 or during the done cycle is ignored; no queueing.
- start and rst asserted together: rst wins.
- rst mid-operation aborts immediately. Partial writes already in RAM C stay; no done pulse.
- Arithmetic:
  - Inputs in [0,q) guarantee outputs in [0,q).
  - Inputs in [0,2q) give outputs in [0,2q); the caller must not rely on canonical form in that case.
  - The controller does not check input ranges.

Decomposition:
- Shared package nh_pkg:
  - NEWHOPE_Q=12289 and NEWHOPE_2Q=24578;
  - COEFF_W=16;
  - N and ADDR_W derivations for the 512 and 1024 parameter sets;
  - state enum type poly_ctrl_state_t {IDLE, RUN, DRAIN}.
- One sub-module: a poly_add_coeff instance as the datapath. The controller holds only the FSM, counter and delay lines.

Test Plan:
- N=8, A[i]=i, B[i]=100+i, one start pulse -> C[i]=100+2i for i=0..7; wr_en high cycles 4..11 with wr_addr 0..7 in order; done only in cycle 12; busy cycles 1..11.
- Reduction boundaries, N=8:
  - A[0]=12288, B[0]=1 -> C[0]=0;
  - A[1]=12288, B[1]=12288 -> C[1]=12287;
  - A[2]=6000, B[2]=6288 -> C[2]=12288;
  - A[3]=0, B[3]=0 -> C[3]=0.
- start re-pulsed in cycles 3 and 12 of a running N=8 operation -> no extra writes and exactly one done; a start in cycle 13 launches a new operation with done in cycle 25.
- rst asserted asynchronously in cycle 6 of N=8 -> busy, wr_en, rd_en fall without a clock edge; no done. A following start produces a correct full result and done exactly N+4 cycles later.
- N=1024, random A,B in [0,12289) -> C matches a (a+b) mod 12289 model for every index; done 1028 cycles after start; zero wr_en cycles outside 4..1027.
- Back-to-back: second start in the cycle immediately after done -> second result correct; no overlap between the two operations' wr_en windows.
